lsu_mem_if: RTL and testbench

//  Load/store unit between the RV32I core datapath and a data memory with a req/ack handshake.
//  - Turns word-only, single-cycle data memory access into full RV32I loads and stores:
//    lb/lh/lw/lbu/lhu/sb/sh/sw, with byte enables and sign/zero extension.
//  - Stalls the core until the memory responds; flags misaligned or illegal accesses and timeouts.

---
 rtl/lsu_mem_if.sv | 115 +++++++++++
 tb/tb_lsu_mem_if.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: RV32I load/store unit that sits between the core datapath and a word-wide data memory
// using a req/ack handshake. It generates the byte enables and the lane-replicated store data, and it
// sign- or zero-extends load results. It holds the core stalled until the memory responds. It flags
// a misaligned access or an illegal funct3 as a fault, and it aborts an access that gets no ack
// within TIMEOUT cycles.
//  clk, reset                       clock and asynchronous active-high reset
//  ls_valid/we/funct3/addr/wdata    access request from the core, held while ls_stall=1
//  ls_stall                         core must hold PC/inputs and suppress regfile write
//  ls_rdata, ls_done                extended load result (0 for stores) with one-cycle completion pulse
//  ls_fault, ls_timeout             one-cycle error pulses
//  mem_req/we/addr/be/wdata         word-aligned memory request, held until mem_ack
//  mem_ack, mem_rdata               memory completion and read word
module lsu_mem_if #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ls_valid,
   input  logic        ls_we,
   input  logic [2:0]  ls_funct3,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_stall,
   output logic [31:0] ls_rdata,
   output logic        ls_done,
   output logic        ls_fault,
   output logic        ls_timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        fault;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [7:0]  rb;
   logic [15:0] rh;
   logic [31:0] ext;
   always_comb begin
      fault = (ls_funct3[1:0] == 2'b11) || (ls_funct3 == 3'b110) || (ls_we && ls_funct3[2]) ||
              (ls_funct3[1:0] == 2'b01 && ls_addr[0]) ||
              (ls_funct3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00);
      be    = !ls_we ? 4'hF :
              ls_funct3[1:0] == 2'b00 ? 4'b0001 << ls_addr[1:0] :
              ls_funct3[1:0] == 2'b01 ? 4'b0011 << ls_addr[1:0] : 4'hF;
      wdata = ls_funct3[1:0] == 2'b00 ? {4{ls_wdata[7:0]}} :
              ls_funct3[1:0] == 2'b01 ? {2{ls_wdata[15:0]}} : ls_wdata;
      rb    = mem_rdata[{off_q, 3'b000} +: 8];
      rh    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      // funct3[2] marks the unsigned variants, so it suppresses the sign fill
      ext   = f3_q[1:0] == 2'b00 ? {{24{rb[7] & ~f3_q[2]}}, rb} :
              f3_q[1:0] == 2'b01 ? {{16{rh[15] & ~f3_q[2]}}, rh} : mem_rdata;
   end
   // The stall and the fault must act in the same cycle the request is presented, so they are
   // combinational. Gating them with reset keeps every output low while reset is asserted.
   assign ls_stall = ~reset & ((state == IDLE & ls_valid & ~fault) | state == REQ);
   assign ls_fault = ~reset & state == IDLE & ls_valid & fault;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         ls_done    <= 1'b0;
         ls_timeout <= 1'b0;
         ls_rdata   <= '0;
      end else begin
         ls_done    <= 1'b0;
         ls_timeout <= 1'b0;
         ls_rdata   <= '0;
         case (state)
            IDLE:
               if (ls_valid && !fault) begin
                  state     <= REQ;
                  cnt       <= '0;
                  mem_req   <= 1'b1;
                  mem_we    <= ls_we;
                  mem_addr  <= {ls_addr[31:2], 2'b00};
                  mem_be    <= be;
                  mem_wdata <= wdata;
                  f3_q      <= ls_funct3;
                  off_q     <= ls_addr[1:0];
               end
            // An ack takes priority over the timeout, even in the final allowed cycle.
            REQ:
               if (mem_ack) begin
                  state    <= DONE;
                  mem_req  <= 1'b0;
                  ls_done  <= 1'b1;
                  ls_rdata <= mem_we ? '0 : ext;
               end else if (cnt == LAST) begin
                  state      <= ERR;
                  mem_req    <= 1'b0;
                  ls_timeout <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_lsu_mem_if.sv
module tb_lsu_mem_if;
   localparam int T = 15;
   logic        clk = 1'b0, reset = 1'b1;
   logic        ls_valid = 1'b0, ls_we = 1'b0;
   logic [2:0]  ls_funct3 = '0;
   logic [31:0] ls_addr = '0, ls_wdata = '0;
   logic        ls_stall, ls_done, ls_fault, ls_timeout, mem_req, mem_we;
   logic [31:0] ls_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   lsu_mem_if #(.TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .ls_valid(ls_valid), .ls_we(ls_we), .ls_funct3(ls_funct3),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_stall(ls_stall), .ls_rdata(ls_rdata),
      .ls_done(ls_done), .ls_fault(ls_fault), .ls_timeout(ls_timeout), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   int total = 0, bad = 0;
   logic chk_en = 1'b0;
   logic e_stall = 0, e_done = 0, e_fault = 0, e_timeout = 0, e_req = 0, e_we = 0;
   logic [31:0] e_rdata = '0, e_addr = '0, e_wdata = '0;
   logic [3:0]  e_be = '0;
   int k, obs_stall, obs_to_k;
   logic obs_req, obs_fault;
   logic [31:0] obs_rd, obs_addr, obs_wd;
   logic [3:0]  obs_be;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", n, act, req, $time);
      end
   endtask

   function automatic bit is_fault(bit we, logic [2:0] f, logic [31:0] a);
      int s = 1 << f[1:0];
      return (f[1:0] == 2'd3) || (f == 3'b110) || (we && f[2]) || ((a % 32'(s)) != 0);
   endfunction

   function automatic logic [31:0] exp_load(logic [2:0] f, logic [31:0] a, logic [31:0] word);
      int s = 1 << f[1:0];
      logic [63:0] m = (64'd1 << (8 * s)) - 64'd1;
      logic [63:0] v = ({32'd0, word} >> (8 * a[1:0])) & m;
      if (!f[2] && v[8 * s - 1]) v = v | ~m;
      return v[31:0];
   endfunction

   function automatic logic [3:0] exp_be(bit we, logic [2:0] f, logic [31:0] a);
      int s = 1 << f[1:0];
      logic [7:0] t = 8'((1 << s) - 1) << a[1:0];
      return we ? t[3:0] : 4'hF;
   endfunction

   function automatic logic [31:0] exp_wd(logic [2:0] f, logic [31:0] d);
      int s = 1 << f[1:0];
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) r[8 * i +: 8] = d[8 * (i % s) +: 8];
      return r;
   endfunction

   always @(negedge clk)
      if (chk_en) begin
         chk("stall", 32'(ls_stall), 32'(e_stall));
         chk("done", 32'(ls_done), 32'(e_done));
         chk("fault", 32'(ls_fault), 32'(e_fault));
         chk("timeout", 32'(ls_timeout), 32'(e_timeout));
         chk("req", 32'(mem_req), 32'(e_req));
         chk("rdata", ls_rdata, e_rdata);
         if (e_req) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_be", 32'(mem_be), 32'(e_be));
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
         end
      end

   task automatic cycle();
      @(negedge clk);
      if (mem_req) begin
         obs_req = 1; obs_addr = mem_addr; obs_be = mem_be; obs_wd = mem_wdata;
      end
      if (ls_done) obs_rd = ls_rdata;
      if (ls_timeout) obs_to_k = k;
      if (ls_stall) obs_stall++;
      if (ls_fault) obs_fault = 1;
      k++;
      @(posedge clk); #1;
   endtask

   task automatic clr_exp();
      e_stall = 0; e_done = 0; e_fault = 0; e_timeout = 0; e_req = 0; e_we = 0; e_rdata = '0;
   endtask

   // wait_n >= T means the memory never answers
   task automatic access(input bit we, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] word, input int wait_n);
      bit flt = is_fault(we, f, a);
      bit acked = wait_n < T;
      int n = acked ? wait_n + 1 : T;
      k = 0; obs_stall = 0; obs_to_k = -1; obs_req = 0; obs_fault = 0; obs_rd = '0;
      ls_valid = 1; ls_we = we; ls_funct3 = f; ls_addr = a; ls_wdata = d; mem_ack = 0;
      clr_exp();
      e_stall = !flt; e_fault = flt;
      cycle();
      if (!flt) begin
         for (int j = 1; j <= n; j++) begin
            mem_ack = (j == wait_n + 1);
            mem_rdata = (j == wait_n + 1) ? word : $urandom;
            clr_exp();
            e_stall = 1; e_req = 1; e_we = we; e_addr = {a[31:2], 2'b00};
            e_be = exp_be(we, f, a); e_wdata = exp_wd(f, d);
            cycle();
         end
         mem_ack = 0; ls_valid = 0; ls_addr = $urandom;
         clr_exp();
         if (acked) begin
            e_done = 1; e_rdata = we ? 32'd0 : exp_load(f, a, word);
         end else e_timeout = 1;
         cycle();
      end
      ls_valid = 0; mem_ack = 1'($urandom); mem_rdata = $urandom;
      clr_exp();
      cycle();
      mem_ack = 0;
   endtask

   initial begin
      chk_en = 1;
      @(negedge clk); @(negedge clk);
      @(posedge clk); #1;
      reset = 0;
      chk("pin_lb", exp_load(3'b000, 32'h63, 32'h8000_0000), 32'hFFFF_FF80);
      chk("pin_lhu", exp_load(3'b101, 32'h62, 32'h8001_0000), 32'h0000_8001);
      access(0, 3'b010, 32'h64, 32'h0, 32'h8000_0019, 2);
      chk("lw_stall_cycles", 32'(obs_stall), 32'd4);
      chk("lw_rdata", obs_rd, 32'h8000_0019);
      access(0, 3'b000, 32'h63, 32'h0, 32'h8012_3456, 0);
      chk("lb_rdata", obs_rd, 32'hFFFF_FF80);
      access(0, 3'b100, 32'h63, 32'h0, 32'h8012_3456, 1);
      chk("lbu_rdata", obs_rd, 32'h0000_0080);
      access(0, 3'b001, 32'h62, 32'h0, 32'h8001_5678, 0);
      chk("lh_rdata", obs_rd, 32'hFFFF_8001);
      access(1, 3'b000, 32'h61, 32'h1234_56AB, 32'h0, 0);
      chk("sb_be", 32'(obs_be), 32'h2);
      chk("sb_wdata", obs_wd, 32'hABAB_ABAB);
      chk("sb_addr", obs_addr, 32'h60);
      chk("sb_rdata", obs_rd, 32'h0);
      access(1, 3'b001, 32'h62, 32'h1234_56AB, 32'h0, 0);
      chk("sh_be", 32'(obs_be), 32'hC);
      access(1, 3'b010, 32'h66, 32'h1, 32'h0, 0);
      chk("sw_mis_fault", 32'(obs_fault), 32'd1);
      chk("sw_mis_noreq", 32'(obs_req), 32'd0);
      access(0, 3'b001, 32'h65, 32'h0, 32'h0, 0);
      chk("lh_mis_fault", 32'(obs_fault), 32'd1);
      chk("lh_mis_noreq", 32'(obs_req), 32'd0);
      access(0, 3'b010, 32'h70, 32'h0, 32'h0, 40);
      chk("timeout_cycle", 32'(obs_to_k), 32'd16);
      access(0, 3'b010, 32'h74, 32'h0, 32'hCAFE_F00D, T - 1);
      chk("ack_at_limit", obs_rd, 32'hCAFE_F00D);
      chk("ack_at_limit_noto", 32'(obs_to_k), 32'hFFFF_FFFF);
      // reset in the middle of a request
      chk_en = 0;
      ls_valid = 1; ls_we = 0; ls_funct3 = 3'b010; ls_addr = 32'h40; mem_ack = 0;
      cycle(); cycle(); cycle();
      chk("pre_rst_req", 32'(mem_req), 32'd1);
      #2 reset = 1;
      #1;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_stall", 32'(ls_stall), 32'd0);
      @(posedge clk); #1;
      ls_valid = 0; reset = 0; mem_ack = 1; mem_rdata = 32'h1111_2222;
      clr_exp();
      chk_en = 1;
      cycle(); cycle();
      mem_ack = 0;
      access(0, 3'b010, 32'h80, 32'h0, 32'h1357_9BDF, 1);
      chk("after_rst_rdata", obs_rd, 32'h1357_9BDF);
      for (int i = 0; i < 300; i++) begin
         int w = ($urandom % 4 == 0) ? int'($urandom % 18) : int'($urandom % 3);
         access(1'($urandom), 3'($urandom), 32'h100 + ($urandom % 64), $urandom, $urandom, w);
      end
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
